// File: rtl/unmatch_drain_ctrl_if.sv
// Handshake bundle between the literal drain controller, the literal FIFO read
// port and the LZ4 sequence packer. The slave view belongs to the controller.
interface unmatch_drain_ctrl_if #(
    parameter int LEN_W = 14,
    parameter int CNT_W = 12
);
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;

    logic             fifo_rd_en;
    logic [31:0]      fifo_dout;
    logic [CNT_W-1:0] fifo_rd_data_count;

    logic [31:0]      lit_data;
    logic [2:0]       lit_bytes;
    logic             lit_last;
    logic             lit_valid;
    logic             lit_ready;

    modport master (
        output req_valid, req_len, fifo_dout, fifo_rd_data_count, lit_ready,
        input  req_ready, fifo_rd_en, lit_data, lit_bytes, lit_last, lit_valid
    );

    modport slave (
        input  req_valid, req_len, fifo_dout, fifo_rd_data_count, lit_ready,
        output req_ready, fifo_rd_en, lit_data, lit_bytes, lit_last, lit_valid
    );
endinterface

// File: rtl/unmatch_drain_ctrl.sv
// Literal FIFO read sequencer: turns one literal-run length into ceil(len/4)
// dword reads and presents each dword with a byte count and a last flag.
module unmatch_drain_ctrl #(
    parameter int LEN_W     = 14,
    parameter int CNT_W     = 12,
    parameter int STALL_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    unmatch_drain_ctrl_if.slave  bus,
    output logic                 busy,
    output logic                 stall_err,
    output logic [15:0]          run_cnt
);
    localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, RD, FLUSH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] rem;
    logic [SW-1:0]    stall_cnt;
    logic [31:0]      lit_data_q;
    logic [2:0]       lit_bytes_q;
    logic             lit_last_q;
    logic             lit_valid_q;

    logic has_data;
    logic consume;
    logic rem_last;
    logic accept;
    logic rd_en;
    logic req_ready_c;

    assign has_data = (bus.fifo_rd_data_count != CNT_W'(0));
    assign consume  = lit_valid_q & bus.lit_ready;
    assign rem_last = (rem <= LEN_W'(4));
    assign accept   = (state == IDLE) & bus.req_valid;

    // A read is only issued when the output slot is free or being emptied
    // this cycle, so backpressure can never drop or duplicate a FIFO word.
    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        rd_en       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = ~rst;
                if (bus.req_valid && bus.req_len != '0) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                rd_en = has_data & (~lit_valid_q | bus.lit_ready);
                if (rd_en && rem_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (consume && lit_last_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            lit_data_q  <= '0;
            lit_bytes_q <= '0;
            lit_last_q  <= 1'b0;
            lit_valid_q <= 1'b0;
            run_cnt     <= '0;
        end else begin
            if (accept && bus.req_len != '0) begin
                rem <= bus.req_len;
            end else if (rd_en) begin
                rem <= rem_last ? '0 : rem - LEN_W'(4);
            end

            // Runs start dword-aligned, so only the final word can be partial.
            if (rd_en) begin
                lit_data_q  <= bus.fifo_dout;
                lit_valid_q <= 1'b1;
                lit_bytes_q <= (rem >= LEN_W'(4)) ? 3'd4 : {1'b0, rem[1:0]};
                lit_last_q  <= rem_last;
            end else if (consume) begin
                lit_valid_q <= 1'b0;
            end

            if ((accept && bus.req_len == '0) ||
                (state == FLUSH && consume && lit_last_q)) begin
                run_cnt <= run_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (state != RD || rd_en) begin
            stall_cnt <= '0;
        end else if (!has_data) begin
            if (32'(stall_cnt) < STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (32'(stall_cnt) + 1 >= STALL_MAX) begin
                stall_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.fifo_rd_en = rd_en;
    assign bus.lit_data   = lit_data_q;
    assign bus.lit_bytes  = lit_bytes_q;
    assign bus.lit_last   = lit_last_q;
    assign bus.lit_valid  = lit_valid_q;
    assign busy           = (state != IDLE) | lit_valid_q;
endmodule

// File: tb/tb_unmatch_drain_ctrl.sv
// Bench for unmatch_drain_ctrl: a run-level scoreboard predicts every output
// word, request readiness, busy and run_cnt from the run lengths alone.
module tb_unmatch_drain_ctrl;
    localparam int LEN_W     = 14;
    localparam int CNT_W     = 12;
    localparam int STALL_MAX = 10;
    localparam int NV        = 9;

    typedef struct {
        int len;
        int words;
        int last_bytes;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } exp_word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        stall_err;
    logic [15:0] run_cnt;

    unmatch_drain_ctrl_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    unmatch_drain_ctrl #(
        .LEN_W(LEN_W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .stall_err(stall_err), .run_cnt(run_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int outstanding   = 0;
    int done_runs     = 0;
    int rd_total      = 0;
    int hs_total      = 0;
    int last_hs_bytes = 0;
    int last_hs_cycle = 0;
    int acc_cycle     = 0;
    int feed_prob     = 100;

    logic [31:0] fifo_q[$];
    logic [31:0] pending[$];
    exp_word_t   exp_q[$];
    vec_t        vecs[NV];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      name, actual, expected, cycle);
    endtask

    task automatic apply_stimulus(input logic valid, input int len, input logic ready);
        bus.req_valid = valid;
        bus.req_len   = LEN_W'(len);
        bus.lit_ready = ready;
    endtask

    // One clock: check at the negedge, then update the scoreboard after the edge.
    task automatic run_cycle();
        logic        acc, hs, rd;
        int          acc_len, w, rb;
        logic [31:0] h_data, d;
        logic [2:0]  h_bytes;
        logic        h_last;
        exp_word_t   e;
        bus.fifo_rd_data_count = CNT_W'(fifo_q.size());
        bus.fifo_dout          = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        @(negedge clk);
        check_output("req_ready", 32'(bus.req_ready), 32'(outstanding == 0));
        check_output("busy", 32'(busy), 32'(outstanding != 0));
        check_output("run_cnt", 32'(run_cnt), 32'(done_runs % 65536));
        if (fifo_q.size() == 0) check_output("rd_en_empty", 32'(bus.fifo_rd_en), 32'(0));
        acc     = bus.req_valid & bus.req_ready;
        acc_len = int'(bus.req_len);
        hs      = bus.lit_valid & bus.lit_ready;
        rd      = bus.fifo_rd_en;
        h_data  = bus.lit_data;
        h_bytes = bus.lit_bytes;
        h_last  = bus.lit_last;
        @(posedge clk);
        #1;
        cycle++;
        if (rd && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            rd_total++;
        end
        if (hs) begin
            check_output("hs_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("lit_data", h_data, e.data);
                check_output("lit_bytes", 32'(h_bytes), 32'(e.bytes));
                check_output("lit_last", 32'(h_last), 32'(e.last));
                outstanding--;
                hs_total++;
                last_hs_bytes = int'(h_bytes);
                last_hs_cycle = cycle;
                if (e.last) done_runs++;
            end
        end
        if (acc) begin
            acc_cycle = cycle;
            if (acc_len == 0) begin
                done_runs++;
            end else begin
                w = (acc_len + 3) / 4;
                for (int i = 0; i < w; i++) begin
                    d  = $urandom;
                    rb = acc_len - 4 * i;
                    pending.push_back(d);
                    exp_q.push_back('{data: d, bytes: 3'((rb >= 4) ? 4 : rb), last: (i == w - 1)});
                end
                outstanding += w;
            end
        end
        if (pending.size() != 0 && $urandom_range(99) < feed_prob)
            fifo_q.push_back(pending.pop_front());
    endtask

    task automatic drain(input int bound);
        int n = 0;
        apply_stimulus(1'b0, 0, 1'b1);
        feed_prob = 100;
        while (outstanding != 0 && n < bound) begin
            run_cycle();
            n++;
        end
        check_output("drain_done", 32'(outstanding == 0), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_req_ready"}, 32'(bus.req_ready), 32'(0));
        check_output({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'(0));
        check_output({tag, "_lit_valid"}, 32'(bus.lit_valid), 32'(0));
        check_output({tag, "_lit_data"}, bus.lit_data, 32'(0));
        check_output({tag, "_lit_bytes"}, 32'(bus.lit_bytes), 32'(0));
        check_output({tag, "_lit_last"}, 32'(bus.lit_last), 32'(0));
        check_output({tag, "_busy"}, 32'(busy), 32'(0));
        check_output({tag, "_stall_err"}, 32'(stall_err), 32'(0));
        check_output({tag, "_run_cnt"}, 32'(run_cnt), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, h0;
        logic v, rdy;
        int len;

        vecs[0] = '{9, 3, 1};
        vecs[1] = '{8, 2, 4};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{1, 1, 1};
        vecs[4] = '{4, 1, 4};
        vecs[5] = '{5, 2, 1};
        vecs[6] = '{6, 2, 2};
        vecs[7] = '{7, 2, 3};
        vecs[8] = '{16383, 4096, 3};

        apply_stimulus(1'b0, 0, 1'b0);
        bus.fifo_rd_data_count = '0;
        bus.fifo_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        $display("[TB] table-driven runs");
        for (int i = 0; i < NV; i++) begin
            r0 = rd_total;
            h0 = hs_total;
            apply_stimulus(1'b1, vecs[i].len, 1'b1);
            run_cycle();
            drain(20000);
            check_output("tbl_words", 32'(hs_total - h0), 32'(vecs[i].words));
            check_output("tbl_reads", 32'(rd_total - r0), 32'(vecs[i].words));
            if (vecs[i].words > 0) begin
                check_output("tbl_last_bytes", 32'(last_hs_bytes), 32'(vecs[i].last_bytes));
                check_output("tbl_latency", 32'(last_hs_cycle - acc_cycle), 32'(vecs[i].words + 1));
            end
        end

        $display("[TB] backpressure hold");
        r0 = rd_total;
        h0 = hs_total;
        apply_stimulus(1'b1, 8, 1'b0);
        run_cycle();
        apply_stimulus(1'b0, 0, 1'b0);
        repeat (6) run_cycle();
        check_output("bp_reads_held", 32'(rd_total - r0), 32'(1));
        check_output("bp_valid_held", 32'(bus.lit_valid), 32'(1));
        drain(100);
        check_output("bp_reads", 32'(rd_total - r0), 32'(2));
        check_output("bp_words", 32'(hs_total - h0), 32'(2));

        $display("[TB] randomized traffic");
        feed_prob = 80;
        for (int i = 0; i < 1500; i++) begin
            v   = (outstanding == 0) && ($urandom_range(99) < 50);
            len = ($urandom_range(3) == 0) ? int'($urandom_range(200)) : int'($urandom_range(12));
            rdy = ($urandom_range(99) < 70);
            apply_stimulus(v, len, rdy);
            run_cycle();
        end
        drain(20000);

        $display("[TB] reset mid-run");
        r0 = rd_total;
        apply_stimulus(1'b1, 16, 1'b1);
        run_cycle();
        apply_stimulus(1'b0, 0, 1'b1);
        run_cycle();
        check_output("rst_one_read", 32'(rd_total - r0), 32'(1));
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        fifo_q.delete();
        pending.delete();
        exp_q.delete();
        outstanding = 0;
        done_runs   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        h0 = hs_total;
        apply_stimulus(1'b1, 4, 1'b1);
        run_cycle();
        drain(100);
        check_output("post_rst_words", 32'(hs_total - h0), 32'(1));
        check_output("post_rst_bytes", 32'(last_hs_bytes), 32'(4));

        $display("[TB] starved FIFO");
        feed_prob = 0;
        r0 = rd_total;
        apply_stimulus(1'b1, 6, 1'b1);
        run_cycle();
        apply_stimulus(1'b0, 0, 1'b1);
        check_output("stall_err_k0", 32'(stall_err), 32'(0));
        for (int k = 1; k <= 20; k++) begin
            run_cycle();
            check_output("stall_err", 32'(stall_err), 32'(k >= STALL_MAX));
        end
        check_output("stall_no_reads", 32'(rd_total - r0), 32'(0));
        drain(100);
        check_output("stall_reads", 32'(rd_total - r0), 32'(2));
        check_output("stall_last_bytes", 32'(last_hs_bytes), 32'(2));
        check_output("stall_err_sticky", 32'(stall_err), 32'(1));
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/unmatch_drain_ctrl.md
Name: unmatch_drain_ctrl

Overview:
Read-side sequencer for the literal (unmatched-byte) FIFO in the LZ4 compressor. It accepts one literal-run length per request from the match engine and issues FIFO dword reads, ceil(len/4) of them, only when data is present and the downstream LZ4 sequence packer can accept it. It presents each dword with a valid-byte count and a last flag. The writer pads every run to a dword boundary (byte_done), so every run starts dword-aligned in the FIFO.

Parameters:
LEN_W, 14, width of the literal run length in bytes (max run 2^LEN_W-1).
CNT_W, 12, width of the FIFO dword occupancy input.
STALL_MAX, 1023, number of cycles in RD state with no FIFO data before stall_err sets.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  literal run request valid
req_len  in  LEN_W  run length in bytes (0 allowed)
req_ready  out  1  controller can accept a request
fifo_rd_en  out  1  FIFO read strobe; FIFO dout is valid in the same cycle
fifo_dout  in  32  FIFO read data, byte 0 in bits [31:24]
fifo_rd_data_count  in  CNT_W  FIFO dwords available, including a padded partial dword
lit_data  out  32  registered literal dword
lit_bytes  out  3  valid bytes in lit_data, 1..4, MSB-first
lit_last  out  1  final dword of the current run
lit_valid  out  1  lit_data holds a word
lit_ready  in  1  packer accepts the word when lit_valid & lit_ready
busy  out  1  run in progress or output word pending
stall_err  out  1  sticky; FIFO starved beyond STALL_MAX
run_cnt  out  16  completed runs, wraps at 2^16

Behaviour:
- Reset values: all outputs 0; state IDLE; remaining-byte counter rem = 0; stall counter = 0. Reset mid-run abandons the run immediately. Rebuilding FIFO state is the system's job.
- States: IDLE, RD, FLUSH.
- IDLE:
  - req_ready = 1.
  - On req_valid with req_len != 0: rem <= req_len, go to RD.
  - On req_valid with req_len == 0: accept, run_cnt += 1, stay in IDLE; no FIFO read, no output word.
- RD:
  - req_ready = 0.
  - fifo_rd_en = (fifo_rd_data_count != 0) & (!lit_valid | lit_ready), combinational.
  - Never assert fifo_rd_en when the count is 0.
- On each fifo_rd_en cycle, at the next edge:
  - lit_data <= fifo_dout; lit_valid <= 1.
  - lit_bytes <= (rem >= 4) ? 4 : rem[1:0].
  - lit_last <= (rem <= 4).
  - rem <= (rem <= 4) ? 0 : rem - 4.
  - If rem <= 4, go to FLUSH.
- Output register:
  - Cleared (lit_valid <= 0) on lit_valid & lit_ready with no simultaneous read.
  - A simultaneous consume and read reloads it in the same cycle, giving back-to-back throughput of 1 dword/clk.
  - lit_data, lit_bytes and lit_last are held stable while lit_valid & !lit_ready.
- FLUSH:
  - No reads.
  - When the last word is consumed (lit_valid & lit_ready & lit_last): run_cnt += 1, go to IDLE.
  - req_ready rises the cycle after the consume. Latency from the final handshake to the next acceptable request is 1 clk.
- Latency: a request accepted at edge N allows fifo_rd_en in cycle N+1 if data is present. lit_valid is then seen from edge N+2.
- busy = (state != IDLE) | lit_valid.
- Stall counter:
  - Increments each RD cycle with fifo_rd_data_count == 0; cleared on any read and in IDLE; saturates.
  - When it reaches STALL_MAX, stall_err <= 1, sticky until rst.
  - The controller keeps waiting; it does not abort.
- Arithmetic: rem is LEN_W bits unsigned; the compare/subtract never underflows. run_cnt wraps modulo 2^16.
- Downstream backpressure never drops or duplicates a FIFO read. Read count per run = ceil(req_len/4) exactly.

Test Plan:
- req_len=9, FIFO count=3, lit_ready=1 -> 3 consecutive fifo_rd_en pulses; lit_bytes 4,4,1; lit_last only on the 3rd; run_cnt=1; req_ready high 1 clk after the last handshake.
- req_len=8, lit_ready low for 5 clks after the first word -> only 1 read during the stall; word held stable; then 2nd read back-to-back on release; lit_bytes 4,4.
- req_len=0 -> accepted in 1 clk, no fifo_rd_en, no lit_valid, run_cnt increments, state stays IDLE.
- req_len=6, FIFO count=0 for 20 clks then 2 -> no rd_en while count is 0; reads resume; lit_bytes 4,2. With STALL_MAX=10, stall_err sets at the 10th starved cycle and stays 1.
- Reset asserted mid-run after 1 of 4 dwords -> all outputs 0 immediately; after release, req_len=4 yields a single word with lit_bytes=4, lit_last=1.
- req_len=16383 (max) with a continuously fed FIFO -> 4096 reads; last word lit_bytes=3; no rem underflow; run_cnt=1.
